axil_crossbar_addr_ot: RTL and testbench
========================================

AXIL_CROSSBAR_ADDR_OT -- requirements
Module: axil_crossbar_addr_ot

Interface
REQ-001 SHALL take parameters S, S_COUNT, M_COUNT, ADDR_WIDTH, M_REGIONS, M_BASE_ADDR, M_ADDR_WIDTH, M_CONNECT, M_SECURE and WC_OUTPUT with the same defaults and meaning as the existing crossbar address decoder.
REQ-002 SHALL take parameter MAX_OUTSTANDING, default 4: maximum accepted-but-uncompleted transactions, range 1..255.
REQ-003 SHALL take parameter CNT_WIDTH = $clog2(MAX_OUTSTANDING+1), derived: outstanding counter width.
REQ-004 One clock and one reset: clk input 1 is the clock; rst input 1 is the reset, asynchronous and active-high.
REQ-005 s_axil_aaddr input ADDR_WIDTH; s_axil_aprot input 3; s_axil_avalid input 1; s_axil_aready output 1.
REQ-006 m_select output $clog2(M_COUNT); m_axil_avalid output 1; m_axil_aready input 1.
REQ-007 m_wc_select output $clog2(M_COUNT); m_wc_decerr output 1; m_wc_valid output 1; m_wc_ready input 1.
REQ-008 m_rc_select output $clog2(M_COUNT); m_rc_decerr output 1; m_rc_valid output 1; m_rc_ready input 1.
REQ-009 m_rc_done input 1: one-cycle pulse per completed response; m_outstanding output CNT_WIDTH: current count.

Function
REQ-010 Decode SHALL match a region when width nonzero, M_CONNECT bit (S+i*S_COUNT) set, secure check passes (!M_SECURE[i] or !aprot[1]), and aaddr>>width equals base>>width; highest matching index wins; no match gives decerr=1.
REQ-011 States: IDLE, STALL, DECODE.
REQ-012 IDLE: on s_axil_avalid && !s_axil_aready, register select/decerr; if admissible, go DECODE, else go STALL.
REQ-013 Admissible: count==0, or (count<MAX_OUTSTANDING, select==cur_select, decerr==cur_decerr).
REQ-014 STALL: re-evaluate admissibility every cycle against the registered decode; go DECODE on the first admissible cycle.
REQ-015 Entering DECODE: m_axil_avalid=!decerr, m_wc_valid=WC_OUTPUT, m_rc_valid=1, valid the following cycle; cur_select/cur_decerr updated.
REQ-016 Each output valid SHALL clear independently on its own ready; once all have cleared, s_axil_aready pulses one cycle, count increments, and the state returns to IDLE.
REQ-017 Minimum latency, avalid to aready: 3 cycles with all readies high.
REQ-018 Increment and m_rc_done in the same cycle: count unchanged; m_rc_done at count==0 ignored, count stays 0.
REQ-019 Valids SHALL never drop before their ready; selects/decerr stable while any valid is high.

Reset
REQ-020 rst: state IDLE, s_axil_aready=0, all valids=0, count=0, cur_decerr=0, cur_select=0, error counter 0; select/decerr registers not reset.
REQ-021 rst mid-transaction SHALL abandon it with no aready pulse; the first post-reset address is treated as count==0.

Configuration
REQ-022 Macro AXIL_CROSSBAR_ADDR_DECERR_CNT_EN defined: adds output m_decerr_count, 16 bits, incremented once per admitted decerr transaction, saturating at 0xFFFF.
REQ-023 Macro undefined: the m_decerr_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-024 M_COUNT=2, 24-bit regions, readies high, addr 0x000010 -> m_select=0, avalid/rc_valid at cycle 1, aready at cycle 3, m_outstanding=1.
REQ-025 Four addresses to master 1 with no m_rc_done, MAX_OUTSTANDING=4 -> four accepted; fifth held in STALL, aready low until an m_rc_done pulse, then accepted with count 4.
REQ-026 Master 0 outstanding=1, new address to master 1 -> STALL; after m_rc_done, count 0 and decode proceeds with m_select=1.
REQ-027 Unmapped addr 0xFF000000 -> m_axil_avalid stays 0, m_rc_decerr=1, rc_valid=1; with macro defined, m_decerr_count=1.
REQ-028 M_SECURE[0]=1, aprot=3'b010, addr in master 0 -> decerr=1; aprot=3'b000 -> select 0.
REQ-029 rst asserted while m_rc_valid high and m_rc_ready low -> all valids 0 and count 0 asynchronously; next address decodes normally.

Source files
------------

// File: rtl/axil_crossbar_addr_ot_if.sv
// Address-channel bundle for axil_crossbar_addr_ot.
// Carries the slave address handshake, the master address/write/read command
// handshakes, the response-completion pulse and the outstanding count.
// Optional member m_decerr_count exists only with AXIL_CROSSBAR_ADDR_DECERR_CNT_EN.
interface axil_crossbar_addr_ot_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int M_COUNT    = 4,
  parameter int CNT_WIDTH  = 3
);
  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  logic [ADDR_WIDTH-1:0] s_axil_aaddr;
  logic [2:0]            s_axil_aprot;
  logic                  s_axil_avalid;
  logic                  s_axil_aready;

  logic [SEL_W-1:0]      m_select;
  logic                  m_axil_avalid;
  logic                  m_axil_aready;

  logic [SEL_W-1:0]      m_wc_select;
  logic                  m_wc_decerr;
  logic                  m_wc_valid;
  logic                  m_wc_ready;

  logic [SEL_W-1:0]      m_rc_select;
  logic                  m_rc_decerr;
  logic                  m_rc_valid;
  logic                  m_rc_ready;

  logic                  m_rc_done;
  logic [CNT_WIDTH-1:0]  m_outstanding;

`ifdef AXIL_CROSSBAR_ADDR_DECERR_CNT_EN
  logic [15:0]           m_decerr_count;

  modport slave (
    input  s_axil_aaddr, s_axil_aprot, s_axil_avalid,
    output s_axil_aready,
    output m_select, m_axil_avalid, input m_axil_aready,
    output m_wc_select, m_wc_decerr, m_wc_valid, input m_wc_ready,
    output m_rc_select, m_rc_decerr, m_rc_valid, input m_rc_ready,
    input  m_rc_done, output m_outstanding,
    output m_decerr_count
  );

  modport master (
    output s_axil_aaddr, s_axil_aprot, s_axil_avalid,
    input  s_axil_aready,
    input  m_select, m_axil_avalid, output m_axil_aready,
    input  m_wc_select, m_wc_decerr, m_wc_valid, output m_wc_ready,
    input  m_rc_select, m_rc_decerr, m_rc_valid, output m_rc_ready,
    output m_rc_done, input m_outstanding,
    input  m_decerr_count
  );
`else
  modport slave (
    input  s_axil_aaddr, s_axil_aprot, s_axil_avalid,
    output s_axil_aready,
    output m_select, m_axil_avalid, input m_axil_aready,
    output m_wc_select, m_wc_decerr, m_wc_valid, input m_wc_ready,
    output m_rc_select, m_rc_decerr, m_rc_valid, input m_rc_ready,
    input  m_rc_done, output m_outstanding
  );

  modport master (
    output s_axil_aaddr, s_axil_aprot, s_axil_avalid,
    input  s_axil_aready,
    input  m_select, m_axil_avalid, output m_axil_aready,
    input  m_wc_select, m_wc_decerr, m_wc_valid, output m_wc_ready,
    input  m_rc_select, m_rc_decerr, m_rc_valid, output m_rc_ready,
    output m_rc_done, input m_outstanding
  );
`endif
endinterface

// File: rtl/axil_crossbar_addr_ot.sv
// AXI-lite crossbar address decoder with outstanding-transaction limiting.
// Decodes an incoming address to a master port, then admits it only when no
// transactions are in flight, or when it targets the same route as those in
// flight and the outstanding limit is not reached. Non-admissible addresses
// wait in STALL until responses drain.
// Optional feature macro: AXIL_CROSSBAR_ADDR_DECERR_CNT_EN adds a saturating
// 16-bit count of admitted decode-error transactions (m_decerr_count).
module axil_crossbar_addr_ot #(
  parameter int S               = 0,
  parameter int S_COUNT         = 4,
  parameter int M_COUNT         = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int M_REGIONS       = 1,
  parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
  parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT{{M_REGIONS{32'd24}}}},
  parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT{{S_COUNT{1'b1}}}},
  parameter logic [M_COUNT-1:0] M_SECURE = {M_COUNT{1'b0}},
  parameter bit   WC_OUTPUT       = 1'b0,
  parameter int   MAX_OUTSTANDING = 4,
  parameter int   CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
  input logic clk,
  input logic rst,
  axil_crossbar_addr_ot_if.slave bus
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_OT = CNT_WIDTH'(MAX_OUTSTANDING);

  // A zero base-address vector means regions are packed back to back, each
  // aligned to its own size, in index order.
  function automatic logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] calc_base_addrs();
    logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] addrs;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] mask;
    int w;
    addrs = '0;
    base  = '0;
    for (int i = 0; i < M_COUNT*M_REGIONS; i++) begin
      w    = int'(M_ADDR_WIDTH[i*32 +: 32]);
      mask = {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - w);
      if (w > 0) begin
        if ((base & mask) != '0) begin
          base = base + mask + ADDR_WIDTH'(1) - (base & mask);
        end else begin
          base = base;
        end
        addrs[i*ADDR_WIDTH +: ADDR_WIDTH] = base;
        base = base + mask + ADDR_WIDTH'(1);
      end else begin
        base = base;
      end
    end
    return addrs;
  endfunction

  localparam logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] BASE_INT =
    (M_BASE_ADDR != '0) ? M_BASE_ADDR : calc_base_addrs();

  // One region hit: enabled, connected to this slave, secure-allowed, prefix equal.
  function automatic logic region_match(input int i, input int j,
                                        input logic [ADDR_WIDTH-1:0] addr,
                                        input logic nonsec);
    int idx;
    int w;
    logic [ADDR_WIDTH-1:0] base;
    idx  = i*M_REGIONS + j;
    w    = int'(M_ADDR_WIDTH[idx*32 +: 32]);
    base = BASE_INT[idx*ADDR_WIDTH +: ADDR_WIDTH];
    return (w != 0) && M_CONNECT[S + i*S_COUNT] && (!M_SECURE[i] || !nonsec) &&
           ((addr >> w) == (base >> w));
  endfunction

  // A new route may join the in-flight ones only if it is identical to them.
  function automatic logic admissible(input logic [CNT_WIDTH-1:0] cnt,
                                      input logic [SEL_W-1:0] sel, input logic dec,
                                      input logic [SEL_W-1:0] cur_sel, input logic cur_dec);
    return (cnt == '0) || ((cnt < MAX_OT) && (sel == cur_sel) && (dec == cur_dec));
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, DECODE = 2'd2} state_t;

  state_t               state_r, state_s;
  logic [SEL_W-1:0]     match_select_s;
  logic                 match_decerr_s;
  logic [SEL_W-1:0]     select_r, select_s, cur_select_r, cur_select_s;
  logic                 decerr_r, decerr_s, cur_decerr_r, cur_decerr_s;
  logic                 aready_r, aready_s;
  logic                 avalid_r, avalid_s, wc_valid_r, wc_valid_s, rc_valid_r, rc_valid_s;
  logic [CNT_WIDTH-1:0] count_r, count_s;
  logic                 admit_s, dec_cnt_s;

  // Address decode; the last (highest) matching master index wins.
  always_comb begin
    match_select_s = '0;
    match_decerr_s = 1'b1;
    for (int i = 0; i < M_COUNT; i++) begin
      for (int j = 0; j < M_REGIONS; j++) begin
        if (region_match(i, j, bus.s_axil_aaddr, bus.s_axil_aprot[1])) begin
          match_select_s = SEL_W'(i);
          match_decerr_s = 1'b0;
        end else begin
          match_select_s = match_select_s;
        end
      end
    end
  end

  // Next state, handshake valids, route latching and outstanding count.
  always_comb begin
    state_s      = state_r;
    select_s     = select_r;
    decerr_s     = decerr_r;
    cur_select_s = cur_select_r;
    cur_decerr_s = cur_decerr_r;
    avalid_s     = avalid_r   && !bus.m_axil_aready;
    wc_valid_s   = wc_valid_r && !bus.m_wc_ready;
    rc_valid_s   = rc_valid_r && !bus.m_rc_ready;
    aready_s     = 1'b0;
    admit_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.s_axil_avalid && !aready_r) begin
          select_s = match_select_s;
          decerr_s = match_decerr_s;
          if (admissible(count_r, match_select_s, match_decerr_s, cur_select_r, cur_decerr_r)) begin
            admit_s = 1'b1;
            state_s = DECODE;
          end else begin
            state_s = STALL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STALL: begin
        if (admissible(count_r, select_r, decerr_r, cur_select_r, cur_decerr_r)) begin
          admit_s = 1'b1;
          state_s = DECODE;
        end else begin
          state_s = STALL;
        end
      end
      DECODE: begin
        if (!avalid_r && !wc_valid_r && !rc_valid_r) begin
          aready_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = DECODE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (admit_s) begin
      avalid_s     = !decerr_s;
      wc_valid_s   = WC_OUTPUT;
      rc_valid_s   = 1'b1;
      cur_select_s = select_s;
      cur_decerr_s = decerr_s;
    end else begin
      cur_select_s = cur_select_s;
    end
    // A completion with nothing outstanding is spurious and dropped.
    dec_cnt_s = bus.m_rc_done && (count_r != '0);
    if (aready_s && !dec_cnt_s) begin
      count_s = count_r + CNT_WIDTH'(1);
    end else if (!aready_s && dec_cnt_s) begin
      count_s = count_r - CNT_WIDTH'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Control state, valids, current route and outstanding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      aready_r     <= 1'b0;
      avalid_r     <= 1'b0;
      wc_valid_r   <= 1'b0;
      rc_valid_r   <= 1'b0;
      cur_select_r <= '0;
      cur_decerr_r <= 1'b0;
      count_r      <= '0;
    end else begin
      state_r      <= state_s;
      aready_r     <= aready_s;
      avalid_r     <= avalid_s;
      wc_valid_r   <= wc_valid_s;
      rc_valid_r   <= rc_valid_s;
      cur_select_r <= cur_select_s;
      cur_decerr_r <= cur_decerr_s;
      count_r      <= count_s;
    end
  end

  // Decode of the pending address; only read after being written in IDLE.
  always_ff @(posedge clk) begin
    select_r <= select_s;
    decerr_r <= decerr_s;
  end

`ifdef AXIL_CROSSBAR_ADDR_DECERR_CNT_EN
  logic [15:0] decerr_count_r;

  // Saturating count of admitted decode-error transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decerr_count_r <= 16'd0;
    end else if (admit_s && decerr_s && (decerr_count_r != 16'hFFFF)) begin
      decerr_count_r <= decerr_count_r + 16'd1;
    end else begin
      decerr_count_r <= decerr_count_r;
    end
  end

  assign bus.m_decerr_count = decerr_count_r;
`endif

  assign bus.s_axil_aready = aready_r;
  assign bus.m_select      = cur_select_r;
  assign bus.m_axil_avalid = avalid_r;
  assign bus.m_wc_select   = cur_select_r;
  assign bus.m_wc_decerr   = cur_decerr_r;
  assign bus.m_wc_valid    = wc_valid_r;
  assign bus.m_rc_select   = cur_select_r;
  assign bus.m_rc_decerr   = cur_decerr_r;
  assign bus.m_rc_valid    = rc_valid_r;
  assign bus.m_outstanding = count_r;

endmodule

// File: tb/tb_axil_crossbar_addr_ot.sv
// Self-checking bench for axil_crossbar_addr_ot: two masters with 24-bit
// regions (bases 0x00000000 and 0x01000000), master 0 secure, WC_OUTPUT on.
`timescale 1ns/1ps
module tb_axil_crossbar_addr_ot;
  localparam int CNT_WIDTH = $clog2(4+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  typedef struct packed { logic sel; logic dec; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  axil_crossbar_addr_ot_if #(.ADDR_WIDTH(32), .M_COUNT(2), .CNT_WIDTH(CNT_WIDTH)) bus();

  axil_crossbar_addr_ot #(
    .S(0), .S_COUNT(1), .M_COUNT(2), .ADDR_WIDTH(32), .M_REGIONS(1),
    .M_ADDR_WIDTH({32'd24, 32'd24}), .M_CONNECT(2'b11), .M_SECURE(2'b01),
    .WC_OUTPUT(1'b1), .MAX_OUTSTANDING(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference decode: 0x00xxxxxx -> master 0 unless non-secure, 0x01xxxxxx -> master 1.
  function automatic exp_t model(input logic [31:0] a, input logic [2:0] p);
    exp_t e;
    e.sel = 1'b0;
    e.dec = 1'b1;
    if (a[31:24] == 8'h00 && !p[1]) begin e.sel = 1'b0; e.dec = 1'b0; end
    if (a[31:24] == 8'h01) begin e.sel = 1'b1; e.dec = 1'b0; end
    return e;
  endfunction

  task automatic wait_accept(input int done_at, output logic ok, output int lat, output int rcc,
                             output logic sel, output logic dec, output logic avs);
    ok = 1'b0; lat = 0; rcc = 0; sel = 1'b0; dec = 1'b0; avs = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.m_rc_valid && rcc == 0) begin rcc = c; sel = bus.m_rc_select; dec = bus.m_rc_decerr; end
      if (bus.m_axil_avalid) avs = 1'b1;
      if (bus.s_axil_aready) begin lat = c; ok = 1'b1; break; end
      bus.m_rc_done = (c == done_at);
    end
    bus.s_axil_avalid = 1'b0;
    bus.m_rc_done = 1'b0;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic [2:0] p, input int done_at,
                            output logic ok, output int lat, output int rcc,
                            output logic sel, output logic dec, output logic avs);
    @(negedge clk);
    bus.s_axil_aaddr = a; bus.s_axil_aprot = p; bus.s_axil_avalid = 1'b1;
    wait_accept(done_at, ok, lat, rcc, sel, dec, avs);
  endtask

  task automatic pulse_done();
    bus.m_rc_done = 1'b1;
    @(negedge clk);
    bus.m_rc_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_axil_aaddr = 32'h0; bus.s_axil_aprot = 3'b000; bus.s_axil_avalid = 1'b0;
    bus.m_axil_aready = 1'b1; bus.m_wc_ready = 1'b1; bus.m_rc_ready = 1'b1; bus.m_rc_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.s_axil_aready !== 1'b0) begin errors++; $display("FAIL rst_aready got %b want 0", bus.s_axil_aready); end
    checks++; if (bus.m_axil_avalid !== 1'b0) begin errors++; $display("FAIL rst_avalid got %b want 0", bus.m_axil_avalid); end
    checks++; if (bus.m_wc_valid !== 1'b0) begin errors++; $display("FAIL rst_wc_valid got %b want 0", bus.m_wc_valid); end
    checks++; if (bus.m_rc_valid !== 1'b0) begin errors++; $display("FAIL rst_rc_valid got %b want 0", bus.m_rc_valid); end
    checks++; if (bus.m_outstanding !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.m_outstanding); end
    checks++; if (bus.m_select !== 1'b0) begin errors++; $display("FAIL rst_select got %b want 0", bus.m_select); end
    checks++; if (bus.m_rc_decerr !== 1'b0) begin errors++; $display("FAIL rst_decerr got %b want 0", bus.m_rc_decerr); end
`ifdef AXIL_CROSSBAR_ADDR_DECERR_CNT_EN
    checks++; if (bus.m_decerr_count !== 16'd0) begin errors++; $display("FAIL rst_decerr_count got %0d want 0", bus.m_decerr_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ok, sel, dec, avs; int lat, rcc; exp_t e;
    exp_q.push_back(model(32'h0000_0010, 3'b000));
    drive_addr(32'h0000_0010, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL basic_latency got %0d (ok=%b) want 3", lat, ok); end
    checks++; if (rcc !== 1) begin errors++; $display("FAIL basic_rc_valid_cycle got %0d want 1", rcc); end
    checks++; if (sel !== e.sel || bus.m_select !== e.sel) begin errors++; $display("FAIL basic_select got %b/%b want %b", sel, bus.m_select, e.sel); end
    checks++; if (dec !== e.dec || avs !== 1'b1) begin errors++; $display("FAIL basic_decerr_avalid got %b/%b want %b/1", dec, avs, e.dec); end
    checks++; if (bus.m_outstanding !== 3'd1) begin errors++; $display("FAIL basic_count got %0d want 1", bus.m_outstanding); end
    @(negedge clk);
    checks++; if (bus.s_axil_aready !== 1'b0) begin errors++; $display("FAIL basic_aready_pulse got %b want 0", bus.s_axil_aready); end
    pulse_done();
    checks++; if (bus.m_outstanding !== 3'd0) begin errors++; $display("FAIL basic_done got %0d want 0", bus.m_outstanding); end
    pulse_done();
    checks++; if (bus.m_outstanding !== 3'd0) begin errors++; $display("FAIL done_at_zero got %0d want 0", bus.m_outstanding); end
  endtask

  task automatic test_max_outstanding();
    logic ok, sel, dec, avs, seen; int lat, rcc; exp_t e;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(model(32'h0100_0000 + 32'(k*16), 3'b000));
      drive_addr(32'h0100_0000 + 32'(k*16), 3'b000, 0, ok, lat, rcc, sel, dec, avs);
      e = exp_q.pop_front();
      checks++; if (!ok || lat !== 3 || sel !== e.sel || dec !== e.dec) begin
        errors++; $display("FAIL max_ot_accept%0d got lat=%0d sel=%b dec=%b want lat=3 sel=%b dec=%b", k, lat, sel, dec, e.sel, e.dec); end
    end
    checks++; if (bus.m_outstanding !== 3'd4) begin errors++; $display("FAIL max_ot_count got %0d want 4", bus.m_outstanding); end
    exp_q.push_back(model(32'h0100_0100, 3'b000));
    @(negedge clk);
    bus.s_axil_aaddr = 32'h0100_0100; bus.s_axil_aprot = 3'b000; bus.s_axil_avalid = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.s_axil_aready || bus.m_rc_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL max_ot_stall got progress=%b want 0", seen); end
    pulse_done();
    checks++; if (bus.m_outstanding !== 3'd3) begin errors++; $display("FAIL max_ot_drain got %0d want 3", bus.m_outstanding); end
    wait_accept(0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || sel !== e.sel || dec !== e.dec) begin errors++; $display("FAIL max_ot_fifth got ok=%b sel=%b dec=%b want 1 %b %b", ok, sel, dec, e.sel, e.dec); end
    checks++; if (bus.m_outstanding !== 3'd4) begin errors++; $display("FAIL max_ot_fifth_count got %0d want 4", bus.m_outstanding); end
    repeat (4) pulse_done();
    checks++; if (bus.m_outstanding !== 3'd0) begin errors++; $display("FAIL max_ot_empty got %0d want 0", bus.m_outstanding); end
  endtask

  task automatic test_switch_master();
    logic ok, sel, dec, avs, seen, moved; int lat, rcc; exp_t e;
    exp_q.push_back(model(32'h0000_0020, 3'b000));
    drive_addr(32'h0000_0020, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || sel !== e.sel || dec !== e.dec) begin errors++; $display("FAIL switch_first got sel=%b dec=%b want %b %b", sel, dec, e.sel, e.dec); end
    exp_q.push_back(model(32'h0100_0020, 3'b000));
    @(negedge clk);
    bus.s_axil_aaddr = 32'h0100_0020; bus.s_axil_aprot = 3'b000; bus.s_axil_avalid = 1'b1;
    seen = 1'b0; moved = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.s_axil_aready || bus.m_rc_valid) seen = 1'b1;
      if (bus.m_select !== 1'b0) moved = 1'b1;
    end
    checks++; if (seen !== 1'b0 || moved !== 1'b0) begin errors++; $display("FAIL switch_stall got progress=%b sel_moved=%b want 0 0", seen, moved); end
    pulse_done();
    checks++; if (bus.m_outstanding !== 3'd0) begin errors++; $display("FAIL switch_drain got %0d want 0", bus.m_outstanding); end
    wait_accept(0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || sel !== e.sel || bus.m_select !== e.sel) begin errors++; $display("FAIL switch_select got ok=%b sel=%b/%b want %b", ok, sel, bus.m_select, e.sel); end
    checks++; if (bus.m_outstanding !== 3'd1) begin errors++; $display("FAIL switch_count got %0d want 1", bus.m_outstanding); end
    pulse_done();
  endtask

  task automatic test_decerr_secure();
    logic ok, sel, dec, avs; int lat, rcc; exp_t e;
    exp_q.push_back(model(32'hFF00_0000, 3'b000));
    drive_addr(32'hFF00_0000, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || dec !== e.dec || avs !== 1'b0 || rcc !== 1) begin
      errors++; $display("FAIL decerr_unmapped got dec=%b avalid_seen=%b rc_cycle=%0d want %b 0 1", dec, avs, rcc, e.dec); end
    checks++; if (bus.m_wc_decerr !== 1'b1 || bus.m_outstanding !== 3'd1) begin
      errors++; $display("FAIL decerr_wc_count got wc_decerr=%b count=%0d want 1 1", bus.m_wc_decerr, bus.m_outstanding); end
`ifdef AXIL_CROSSBAR_ADDR_DECERR_CNT_EN
    checks++; if (bus.m_decerr_count !== 16'd1) begin errors++; $display("FAIL decerr_count got %0d want 1", bus.m_decerr_count); end
`endif
    pulse_done();
    exp_q.push_back(model(32'h0000_0100, 3'b010));
    drive_addr(32'h0000_0100, 3'b010, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || dec !== e.dec || avs !== 1'b0) begin errors++; $display("FAIL secure_nonsec got dec=%b avalid_seen=%b want %b 0", dec, avs, e.dec); end
    pulse_done();
    exp_q.push_back(model(32'h0000_0100, 3'b000));
    drive_addr(32'h0000_0100, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || dec !== e.dec || sel !== e.sel || avs !== 1'b1) begin errors++; $display("FAIL secure_ok got sel=%b dec=%b want %b %b", sel, dec, e.sel, e.dec); end
`ifdef AXIL_CROSSBAR_ADDR_DECERR_CNT_EN
    checks++; if (bus.m_decerr_count !== 16'd2) begin errors++; $display("FAIL secure_decerr_count got %0d want 2", bus.m_decerr_count); end
`endif
    pulse_done();
  endtask

  task automatic test_back_to_back();
    logic ok, sel, dec, avs; int lat, rcc;
    drive_addr(32'h0100_0200, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    checks++; if (!ok || bus.m_outstanding !== 3'd1) begin errors++; $display("FAIL b2b_first got count=%0d want 1", bus.m_outstanding); end
    drive_addr(32'h0100_0204, 3'b000, 2, ok, lat, rcc, sel, dec, avs);
    checks++; if (!ok || lat !== 3 || bus.m_outstanding !== 3'd1) begin
      errors++; $display("FAIL b2b_inc_and_done got lat=%0d count=%0d want 3 1", lat, bus.m_outstanding); end
    drive_addr(32'h0100_0208, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    checks++; if (!ok || bus.m_outstanding !== 3'd2) begin errors++; $display("FAIL b2b_third got count=%0d want 2", bus.m_outstanding); end
    repeat (2) pulse_done();
  endtask

  task automatic test_reset_mid();
    logic ok, sel, dec, avs, seen; int lat, rcc; exp_t e;
    drive_addr(32'h0000_0030, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    bus.m_rc_ready = 1'b0;
    @(negedge clk);
    bus.s_axil_aaddr = 32'h0000_0034; bus.s_axil_aprot = 3'b000; bus.s_axil_avalid = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.s_axil_aready) seen = 1'b1; end
    checks++; if (bus.m_rc_valid !== 1'b1 || bus.m_outstanding !== 3'd1) begin
      errors++; $display("FAIL mid_hold got rc_valid=%b count=%0d want 1 1", bus.m_rc_valid, bus.m_outstanding); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.m_rc_valid !== 1'b0 || bus.m_axil_avalid !== 1'b0 || bus.m_wc_valid !== 1'b0 || bus.m_outstanding !== 3'd0) begin
      errors++; $display("FAIL mid_async_rst got rc=%b a=%b wc=%b count=%0d want 0 0 0 0", bus.m_rc_valid, bus.m_axil_avalid, bus.m_wc_valid, bus.m_outstanding); end
    bus.s_axil_avalid = 1'b0; bus.m_rc_ready = 1'b1;
    repeat (2) begin @(negedge clk); if (bus.s_axil_aready) seen = 1'b1; end
    rst = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_aready got %b want 0", seen); end
    exp_q.push_back(model(32'h0100_0030, 3'b000));
    drive_addr(32'h0100_0030, 3'b000, 0, ok, lat, rcc, sel, dec, avs);
    e = exp_q.pop_front();
    checks++; if (!ok || lat !== 3 || sel !== e.sel || dec !== e.dec || bus.m_outstanding !== 3'd1) begin
      errors++; $display("FAIL post_rst_decode got lat=%0d sel=%b dec=%b count=%0d want 3 %b %b 1", lat, sel, dec, bus.m_outstanding, e.sel, e.dec); end
    pulse_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_max_outstanding();
    test_switch_master();
    test_decerr_secure();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
